hdmi_timing_gen: RTL and testbench

Free-running HDMI/DVI timing generator, downstream of the Amiga video analyzer. Produces CEA-861 720x576p50 or 720x480p60 sync, data-enable and pixel coordinates. Mode selection comes from the analyzer's `pal` flag. The analyzer's `vreset` pulse re-aligns the counters to the first active pixel, so the Amiga image lands at a fixed position in the HDMI frame.

---
 rtl/hdmi_timing_gen.sv | 196 +++++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: free-running CEA-861 720x576p50 / 720x480p60 timing generator.
// Pixel/line counters with a one-stage registered sync/DE decode, a frame-aligned
// mode latch, a two-state lock tracker and an interlace field toggle.
module hdmi_timing_gen #(
   parameter int H_ACT     = 720,
   parameter int PAL_HTOT  = 864,
   parameter int PAL_HFP   = 12,
   parameter int PAL_HSW   = 64,
   parameter int PAL_VTOT  = 625,
   parameter int PAL_VACT  = 576,
   parameter int PAL_VFP   = 5,
   parameter int PAL_VSW   = 5,
   parameter int NTSC_HTOT = 858,
   parameter int NTSC_HFP  = 16,
   parameter int NTSC_HSW  = 62,
   parameter int NTSC_VTOT = 525,
   parameter int NTSC_VACT = 480,
   parameter int NTSC_VFP  = 9,
   parameter int NTSC_VSW  = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pal,
   input  logic       interlace,
   input  logic       vreset,
   output logic       hs_n,
   output logic       vs_n,
   output logic       de,
   output logic [9:0] hcnt,
   output logic [9:0] vcnt,
   output logic       mode_pal,
   output logic       locked,
   output logic       field
);

   // Per-mode timing constants, pre-reduced to 10-bit compare values.
   localparam logic [9:0] H_ACT_W      = 10'(H_ACT);
   localparam logic [9:0] PAL_H_LAST   = 10'(PAL_HTOT - 1);
   localparam logic [9:0] PAL_V_LAST   = 10'(PAL_VTOT - 1);
   localparam logic [9:0] PAL_VACT_W   = 10'(PAL_VACT);
   localparam logic [9:0] PAL_HS_BEG   = 10'(H_ACT + PAL_HFP);
   localparam logic [9:0] PAL_HS_END   = 10'(H_ACT + PAL_HFP + PAL_HSW);
   localparam logic [9:0] PAL_VS_BEG   = 10'(PAL_VACT + PAL_VFP);
   localparam logic [9:0] PAL_VS_END   = 10'(PAL_VACT + PAL_VFP + PAL_VSW);
   localparam logic [9:0] NTSC_H_LAST  = 10'(NTSC_HTOT - 1);
   localparam logic [9:0] NTSC_V_LAST  = 10'(NTSC_VTOT - 1);
   localparam logic [9:0] NTSC_VACT_W  = 10'(NTSC_VACT);
   localparam logic [9:0] NTSC_HS_BEG  = 10'(H_ACT + NTSC_HFP);
   localparam logic [9:0] NTSC_HS_END  = 10'(H_ACT + NTSC_HFP + NTSC_HSW);
   localparam logic [9:0] NTSC_VS_BEG  = 10'(NTSC_VACT + NTSC_VFP);
   localparam logic [9:0] NTSC_VS_END  = 10'(NTSC_VACT + NTSC_VFP + NTSC_VSW);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   logic [9:0]  r_h;
   logic [9:0]  r_v;
   logic        r_run;
   logic        r_mode_pal;
   lock_state_t r_state;
   logic        r_locked;
   logic        r_field;
   logic        r_de;
   logic        r_hs_n;
   logic        r_vs_n;

   logic [9:0]  w_h_last;
   logic [9:0]  w_v_last;
   logic [9:0]  w_vact;
   logic [9:0]  w_hs_beg;
   logic [9:0]  w_hs_end;
   logic [9:0]  w_vs_beg;
   logic [9:0]  w_vs_end;
   logic        w_line_wrap;
   logic        w_frame_wrap;
   logic        w_mode_change;

   // The table in effect is always the latched mode, never the raw request.
   assign w_h_last  = r_mode_pal ? PAL_H_LAST : NTSC_H_LAST;
   assign w_v_last  = r_mode_pal ? PAL_V_LAST : NTSC_V_LAST;
   assign w_vact    = r_mode_pal ? PAL_VACT_W : NTSC_VACT_W;
   assign w_hs_beg  = r_mode_pal ? PAL_HS_BEG : NTSC_HS_BEG;
   assign w_hs_end  = r_mode_pal ? PAL_HS_END : NTSC_HS_END;
   assign w_vs_beg  = r_mode_pal ? PAL_VS_BEG : NTSC_VS_BEG;
   assign w_vs_end  = r_mode_pal ? PAL_VS_END : NTSC_VS_END;

   // Wrap events only exist once the counters are running.
   assign w_line_wrap   = r_run && (r_h == w_h_last);
   assign w_frame_wrap  = w_line_wrap && (r_v == w_v_last);
   assign w_mode_change = w_frame_wrap && (pal != r_mode_pal);

   // First cycle after reset release is a hold cycle: counters and decode stay put.
   // NOTE: every state register below uses non-blocking assignments so all flops
   // sample the same pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // Pixel and line counters; vreset re-aligns to the first active pixel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h <= '0;
         r_v <= '0;
      end else if (r_run) begin
         if (vreset) begin
            r_h <= '0;
            r_v <= '0;
         end else if (w_line_wrap) begin
            r_h <= '0;
            r_v <= w_frame_wrap ? 10'd0 : r_v + 10'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   // Mode latch: follows the request only at a frame boundary or on re-alignment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode_pal <= 1'b1;
      end else if (r_run && (vreset || w_frame_wrap)) begin
         r_mode_pal <= pal;
      end
   end

   // Lock tracker: vreset acquires lock, a pending mode change at the frame wrap drops it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_SEARCH;
         r_locked <= 1'b0;
      end else if (r_run) begin
         case (r_state)
            ST_SEARCH: begin
               if (vreset) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (!vreset && w_mode_change) begin
                  r_state  <= ST_SEARCH;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   // Field flag: toggles per frame for interlaced sources, otherwise held at 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_field <= 1'b0;
      end else if (r_run) begin
         if (vreset) begin
            if (!interlace) begin
               r_field <= 1'b0;
            end
         end else if (w_frame_wrap) begin
            r_field <= interlace ? ~r_field : 1'b0;
         end
      end
   end

   // Registered position decode, one cycle behind the counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_de   <= 1'b0;
         r_hs_n <= 1'b1;
         r_vs_n <= 1'b1;
      end else if (r_run) begin
         r_de   <= (r_h < H_ACT_W) && (r_v < w_vact);
         r_hs_n <= !((r_h >= w_hs_beg) && (r_h < w_hs_end));
         r_vs_n <= !((r_v >= w_vs_beg) && (r_v < w_vs_end));
      end
   end

   assign hs_n     = r_hs_n;
   assign vs_n     = r_vs_n;
   assign de       = r_de;
   assign hcnt     = r_h;
   assign vcnt     = r_v;
   assign mode_pal = r_mode_pal;
   assign locked   = r_locked;
   assign field    = r_field;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: table-driven checkpoints plus a per-cycle scoreboard.
// Horizontal timing uses the real CEA-861 values; the vertical totals are scaled
// down through the parameters so that several frame wraps fit in a short run.
module tb_hdmi_timing_gen;

   localparam int T_H_ACT     = 720;
   localparam int T_PAL_HTOT  = 864;
   localparam int T_PAL_HFP   = 12;
   localparam int T_PAL_HSW   = 64;
   localparam int T_PAL_VTOT  = 12;
   localparam int T_PAL_VACT  = 6;
   localparam int T_PAL_VFP   = 2;
   localparam int T_PAL_VSW   = 3;
   localparam int T_NTSC_HTOT = 858;
   localparam int T_NTSC_HFP  = 16;
   localparam int T_NTSC_HSW  = 62;
   localparam int T_NTSC_VTOT = 10;
   localparam int T_NTSC_VACT = 5;
   localparam int T_NTSC_VFP  = 1;
   localparam int T_NTSC_VSW  = 2;

   localparam int MAX_ERRORS  = 40;

   logic       clk;
   logic       reset_n;
   logic       pal;
   logic       interlace;
   logic       vreset;
   logic       hs_n;
   logic       vs_n;
   logic       de;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       mode_pal;
   logic       locked;
   logic       field;

   hdmi_timing_gen #(
      .H_ACT    (T_H_ACT),
      .PAL_HTOT (T_PAL_HTOT),  .PAL_HFP (T_PAL_HFP),  .PAL_HSW (T_PAL_HSW),
      .PAL_VTOT (T_PAL_VTOT),  .PAL_VACT(T_PAL_VACT), .PAL_VFP (T_PAL_VFP),  .PAL_VSW (T_PAL_VSW),
      .NTSC_HTOT(T_NTSC_HTOT), .NTSC_HFP(T_NTSC_HFP), .NTSC_HSW(T_NTSC_HSW),
      .NTSC_VTOT(T_NTSC_VTOT), .NTSC_VACT(T_NTSC_VACT), .NTSC_VFP(T_NTSC_VFP), .NTSC_VSW(T_NTSC_VSW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .pal      (pal),
      .interlace(interlace),
      .vreset   (vreset),
      .hs_n     (hs_n),
      .vs_n     (vs_n),
      .de       (de),
      .hcnt     (hcnt),
      .vcnt     (vcnt),
      .mode_pal (mode_pal),
      .locked   (locked),
      .field    (field)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
         if (errors >= MAX_ERRORS) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   endtask

   // Reference model state.
   logic       m_run;
   int         m_h;
   int         m_v;
   logic       m_mode;
   logic       m_locked;
   logic       m_field;

   // Scoreboard of expected {de, hs_n, vs_n}, pushed when the cycle is driven.
   logic [2:0] sb_q[$];

   task automatic model_reset();
      m_run    = 1'b0;
      m_h      = 0;
      m_v      = 0;
      m_mode   = 1'b1;
      m_locked = 1'b0;
      m_field  = 1'b0;
      sb_q.delete();
   endtask

   function automatic logic [2:0] model_decode();
      int  htot_hs_beg;
      int  hs_len;
      int  vact;
      int  vs_beg;
      int  vs_len;
      logic e_de;
      logic e_hs;
      logic e_vs;
      if (!m_run) return 3'b011;
      htot_hs_beg = T_H_ACT + (m_mode ? T_PAL_HFP : T_NTSC_HFP);
      hs_len      = m_mode ? T_PAL_HSW : T_NTSC_HSW;
      vact        = m_mode ? T_PAL_VACT : T_NTSC_VACT;
      vs_beg      = vact + (m_mode ? T_PAL_VFP : T_NTSC_VFP);
      vs_len      = m_mode ? T_PAL_VSW : T_NTSC_VSW;
      e_de = (m_h < T_H_ACT) && (m_v < vact);
      e_hs = !((m_h >= htot_hs_beg) && (m_h < htot_hs_beg + hs_len));
      e_vs = !((m_v >= vs_beg) && (m_v < vs_beg + vs_len));
      return {e_de, e_hs, e_vs};
   endfunction

   task automatic model_advance(input logic p, input logic il, input logic vr);
      int   htot;
      int   vtot;
      logic end_line;
      logic end_frame;
      if (!m_run) begin
         m_run = 1'b1;
         return;
      end
      htot      = m_mode ? T_PAL_HTOT : T_NTSC_HTOT;
      vtot      = m_mode ? T_PAL_VTOT : T_NTSC_VTOT;
      end_line  = (m_h == htot - 1);
      end_frame = end_line && (m_v == vtot - 1);
      if (vr) m_locked = 1'b1;
      else if (end_frame && (p != m_mode)) m_locked = 1'b0;
      if (vr) begin
         if (!il) m_field = 1'b0;
      end else if (end_frame) begin
         m_field = il ? ~m_field : 1'b0;
      end
      if (vr || end_frame) m_mode = p;
      if (vr) begin
         m_h = 0;
         m_v = 0;
      end else if (end_line) begin
         m_h = 0;
         m_v = end_frame ? 0 : m_v + 1;
      end else begin
         m_h = m_h + 1;
      end
   endtask

   // One clock: drive inputs, queue the expected decode, advance, compare.
   task automatic tick(input logic p, input logic il, input logic vr);
      logic [2:0]  exp_dec;
      logic [31:0] got_v;
      logic [31:0] exp_v;
      pal       = p;
      interlace = il;
      vreset    = vr;
      sb_q.push_back(model_decode());
      model_advance(p, il, vr);
      @(posedge clk);
      #1;
      exp_dec = sb_q.pop_front();
      got_v = {6'd0, hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n};
      exp_v = {6'd0, 10'(m_h), 10'(m_v), m_mode, m_locked, m_field, exp_dec};
      check("cycle", got_v, exp_v);
   endtask

   typedef struct {
      logic       pal;
      logic       il;
      logic       vr;
      int         n;
      logic [9:0] h;
      logic [9:0] v;
      logic       mode;
      logic       lock;
      logic       fld;
      logic       de;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t vecs[27];

   function automatic logic [31:0] pack_state(input logic [9:0] h, input logic [9:0] v,
                                              input logic md, input logic lk, input logic fl,
                                              input logic d, input logic hs, input logic vs);
      return {6'd0, h, v, md, lk, fl, d, hs, vs};
   endfunction

   initial begin
      //           pal   il    vr    n      h    v   mode lock fld  de   hs   vs
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 3351,  760, 3,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b1}; // PAL mid-hsync
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1,     0,   0,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b1}; // vreset mid-sync
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1,     1,   0,  1'b1,1'b1,1'b0,1'b1,1'b1,1'b1}; // de one later
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 6911,  0,   8,  1'b1,1'b1,1'b0,1'b0,1'b1,1'b1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1,     1,   8,  1'b1,1'b1,1'b0,1'b0,1'b1,1'b0}; // vsync start
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 3454,  863, 11, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1}; // pal=0 mid-frame
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1,     0,   0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b1}; // wrap: mode, unlock
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 737,   737, 0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1}; // NTSC hsync at 736
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 61,    798, 0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1}; // last hsync pixel
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1,     799, 0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b1}; // hsync 62 wide
      vecs[10] = '{1'b0, 1'b0, 1'b0, 59,    0,   1,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b1}; // line = 858
      vecs[11] = '{1'b0, 1'b0, 1'b0, 4291,  1,   6,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0}; // NTSC vsync
      vecs[12] = '{1'b1, 1'b0, 1'b1, 1,     0,   0,  1'b1,1'b1,1'b0,1'b0,1'b1,1'b0}; // vreset takes pal
      vecs[13] = '{1'b1, 1'b1, 1'b0, 10367, 863, 11, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1,     0,   0,  1'b1,1'b1,1'b1,1'b0,1'b1,1'b1}; // field 1
      vecs[15] = '{1'b1, 1'b1, 1'b0, 10368, 0,   0,  1'b1,1'b1,1'b0,1'b0,1'b1,1'b1}; // field 0
      vecs[16] = '{1'b1, 1'b1, 1'b0, 10368, 0,   0,  1'b1,1'b1,1'b1,1'b0,1'b1,1'b1}; // field 1
      vecs[17] = '{1'b0, 1'b1, 1'b0, 10367, 863, 11, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b1};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 1,     0,   0,  1'b0,1'b1,1'b1,1'b0,1'b1,1'b1}; // vreset at wrap wins
      vecs[19] = '{1'b0, 1'b0, 1'b0, 8579,  857, 9,  1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 1,     0,   0,  1'b0,1'b1,1'b0,1'b0,1'b1,1'b1}; // field forced 0
      vecs[21] = '{1'b0, 1'b1, 1'b0, 8580,  0,   0,  1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 1,     0,   0,  1'b0,1'b1,1'b0,1'b1,1'b1,1'b1}; // vreset clears field
      vecs[23] = '{1'b1, 1'b0, 1'b0, 8579,  857, 9,  1'b0,1'b1,1'b0,1'b0,1'b1,1'b1};
      vecs[24] = '{1'b1, 1'b0, 1'b0, 1,     0,   0,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b1}; // locked drops
      vecs[25] = '{1'b1, 1'b0, 1'b1, 1,     0,   0,  1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
      vecs[26] = '{1'b1, 1'b0, 1'b0, 2228,  500, 2,  1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};

      reset_n   = 1'b0;
      pal       = 1'b1;
      interlace = 1'b0;
      vreset    = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", pack_state(hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n),
            pack_state(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

      reset_n = 1'b1;
      tick(1'b1, 1'b0, 1'b0);
      check("hold_cycle", pack_state(hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n),
            pack_state(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      tick(1'b1, 1'b0, 1'b0);
      check("first_de", pack_state(hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n),
            pack_state(10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));

      for (int i = 0; i < 27; i++) begin
         for (int c = 0; c < vecs[i].n; c++) begin
            tick(vecs[i].pal, vecs[i].il, (c == 0) ? vecs[i].vr : 1'b0);
         end
         check($sformatf("row%0d", i),
               pack_state(hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n),
               pack_state(vecs[i].h, vecs[i].v, vecs[i].mode, vecs[i].lock, vecs[i].fld,
                          vecs[i].de, vecs[i].hs, vecs[i].vs));
      end

      // Asynchronous reset mid-frame, with no clock edge in between.
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset", pack_state(hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n),
            pack_state(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      check("restart", pack_state(hcnt, vcnt, mode_pal, locked, field, de, hs_n, vs_n),
            pack_state(10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      for (int c = 0; c < 900; c++) tick(1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
